// File: rtl/elliptic_curve_structs.sv
// Shared curve types for the MSM datapath, plus the state encoding of the job sequencer
// that feeds the msm_naive engine.
package elliptic_curve_structs;

    localparam int unsigned COORD_W  = 256;
    localparam int unsigned SCALAR_W = 256;
    localparam int unsigned RESULT_W = 2 * COORD_W;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } msm_seq_state_t;

endpackage

// File: rtl/msm_job_sequencer.sv
// Host for msm_naive: buffers LENGTH (point, scalar) pairs, pulses the engine reset, waits for
// Done and returns {Rx, Ry}. Define MSM_SEQ_TIMEOUT_EN to abort jobs whose Done never arrives.
module msm_job_sequencer
    import elliptic_curve_structs::*;
#(
    parameter int unsigned LENGTH         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  curve_point_t                    in_G,
    input  logic [SCALAR_W-1:0]             in_x,
    output logic                            eng_Reset,
    output curve_point_t [LENGTH-1:0]       eng_G,
    output logic [LENGTH-1:0][SCALAR_W-1:0] eng_x,
    input  logic [RESULT_W-1:0]             eng_R,
    input  logic                            eng_Done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RESULT_W-1:0]             out_R,
    output logic                            out_err,
    output logic                            busy,
    output msm_seq_state_t                  o_dbg_state
);

    // Both streams transfer on a clock edge where valid && ready are high; a producer holds its
    // payload and valid until that edge, and ready never depends combinationally on valid.

    localparam int unsigned          IDX_W    = $clog2(LENGTH + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(LENGTH - 1);

    if (LENGTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("msm_job_sequencer: LENGTH and TIMEOUT_CYCLES must be >= 1");
    end

    msm_seq_state_t                  r_state;
    msm_seq_state_t                  w_state_next;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_in_ready;
    logic                            r_eng_reset;
    logic                            r_out_valid;
    logic                            r_wait_first;
    logic [RESULT_W-1:0]             r_out_r;
    curve_point_t [LENGTH-1:0]       r_g_buf;
    logic [LENGTH-1:0][SCALAR_W-1:0] r_x_buf;
    logic                            w_accept;
    logic                            w_done_hit;
    logic                            w_timeout;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_hit   = 1'b0;
        case (r_state)
            LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_next = START;
                    end
                end
            end
            START: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                // Done seen in the first WAIT cycle can still belong to the previous job.
                if (eng_Done && !r_wait_first) begin
                    w_done_hit   = 1'b1;
                    w_state_next = RESULT;
                end else if (w_timeout) begin
                    w_state_next = RESULT;
                end
            end
            RESULT: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= LOAD;
            r_idx        <= '0;
            r_in_ready   <= 1'b0;
            r_eng_reset  <= 1'b1;
            r_out_valid  <= 1'b0;
            r_wait_first <= 1'b0;
            r_out_r      <= '0;
            r_g_buf      <= '0;
            r_x_buf      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_in_ready   <= (w_state_next == LOAD);
            r_eng_reset  <= (w_state_next == START);
            r_out_valid  <= (w_state_next == RESULT);
            r_wait_first <= (w_state_next == WAIT) && (r_state != WAIT);
            if (w_accept) begin
                r_g_buf[r_idx] <= in_G;
                r_x_buf[r_idx] <= in_x;
                r_idx          <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_done_hit) begin
                r_out_r <= eng_R;
            end else if (w_timeout) begin
                r_out_r <= '0;
            end
        end
    end

`ifdef MSM_SEQ_TIMEOUT_EN
    logic [31:0] r_wait_cnt;
    logic        r_out_err;

    // Done arriving in the timeout cycle takes priority over the abort.
    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1))
                       && !(eng_Done && !r_wait_first);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 32'd1 : 32'd0;
            if (w_done_hit) begin
                r_out_err <= 1'b0;
            end else if (w_timeout) begin
                r_out_err <= 1'b1;
            end
        end
    end

    assign out_err = r_out_err;
`else
    assign w_timeout = 1'b0;
    assign out_err   = 1'b0;
`endif

    assign in_ready    = r_in_ready;
    assign eng_Reset   = r_eng_reset;
    assign eng_G       = r_g_buf;
    assign eng_x       = r_x_buf;
    assign out_valid   = r_out_valid;
    assign out_R       = r_out_r;
    assign busy        = (r_state != LOAD);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msm_job_sequencer.sv
// Self-checking bench for msm_job_sequencer with a stand-in engine whose result is an
// order-sensitive function of the buffered pairs; results are checked through a scoreboard queue.
module tb_msm_job_sequencer;
  import elliptic_curve_structs::*;

  localparam int LEN = 3;
  localparam int W   = 513;
`ifdef MSM_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1048576;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       Reset;
  logic                       in_valid;
  logic                       in_ready;
  curve_point_t               in_G;
  logic [255:0]               in_x;
  logic                       eng_Reset;
  curve_point_t [LEN-1:0]     eng_G;
  logic [LEN-1:0][255:0]      eng_x;
  logic [511:0]               eng_R;
  logic                       eng_Done;
  logic                       out_valid;
  logic                       out_ready;
  logic [511:0]               out_R;
  logic                       out_err;
  logic                       busy;
  msm_seq_state_t             dbg_state;

  msm_job_sequencer #(.LENGTH(LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_G(in_G), .in_x(in_x),
    .eng_Reset(eng_Reset), .eng_G(eng_G), .eng_x(eng_x), .eng_R(eng_R), .eng_Done(eng_Done),
    .out_valid(out_valid), .out_ready(out_ready), .out_R(out_R), .out_err(out_err),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];
  bit stale_q[$];
  int n_pulse = 0;
  int ready_mode = 2;  // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Stand-in engine math: any order-sensitive mix of the pairs exposes slot or data errors.
  function automatic logic [511:0] engine_fn(input curve_point_t [LEN-1:0] g,
                                             input logic [LEN-1:0][255:0] x);
    logic [255:0] rx;
    logic [255:0] ry;
    rx = '0;
    ry = '0;
    for (int i = 0; i < LEN; i++) begin
      rx = rx + g[i].x + x[i] * 256'(i + 1);
      ry = ry ^ g[i].y ^ (x[i] << i);
    end
    return {rx, ry};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // stand-in engine: latency and stale-Done behaviour come per job from lat_q/stale_q
  logic         eng_rst_d = 1'b1;
  int           eng_cnt = 0;
  logic [511:0] eng_pend = '0;
  initial begin
    eng_R    = '0;
    eng_Done = 1'b0;
  end
  always @(posedge clk) begin
    eng_rst_d <= eng_Reset;
    if (eng_Reset && !eng_rst_d && lat_q.size() > 0) begin
      eng_cnt  <= lat_q.pop_front();
      eng_pend <= engine_fn(eng_G, eng_x);
      if (!stale_q.pop_front()) eng_Done <= 1'b0;
    end else if (eng_Reset) begin
      eng_cnt  <= 0;
      eng_Done <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt  <= eng_cnt - 1;
      eng_Done <= (eng_cnt == 1);
      if (eng_cnt == 1) eng_R <= eng_pend;
    end
  end

  // consumer ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    bit           stall_d;
    bit           hs_d;
    logic [511:0] stall_r;
    int           rst_w;
    logic [W-1:0] e;
    stall_d = 0; hs_d = 0; stall_r = '0; rst_w = 0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        stall_d = 0; hs_d = 0; rst_w = 0;
      end else begin
        if (hs_d) begin
          check("in_ready_after_hs", in_ready, 1);
          check("out_valid_drop", out_valid, 0);
        end
        if (stall_d) begin
          check("stall_valid", out_valid, 1);
          check("stall_out_R", out_R, stall_r);
          check("stall_in_ready", in_ready, 0);
        end
        hs_d = 0;
        stall_d = 0;
        if (out_valid) begin
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("result", {out_err, out_R}, e);
            end
            hs_d = 1;
          end else begin
            stall_d = 1;
            stall_r = out_R;
          end
        end
        if (eng_Reset) begin
          rst_w++;
          if (rst_w == 1) n_pulse++;
        end else begin
          if (rst_w > 0) check("eng_reset_width", rst_w, 1);
          rst_w = 0;
        end
      end
    end
  end

  // driver tasks (always entered and left at posedge + 1)
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_G = '{x: rand256(), y: rand256()};
      in_x = rand256();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pair(input curve_point_t g, input logic [255:0] x);
    int guard;
    bit ok;
    guard = 0;
    ok = 0;
    in_valid = 1'b1;
    in_G = g;
    in_x = x;
    while (!ok && guard < 400) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) check("pair_accept_timeout", 0, 1);
  endtask

  // mode 0: normal result expected, 1: job will be aborted, 2: timeout result expected
  task automatic run_job(input curve_point_t [LEN-1:0] g, input logic [LEN-1:0][255:0] x,
                         input int lat, input bit stale, input int gap_lo, input int gap_hi,
                         input int mode);
    lat_q.push_back(lat);
    stale_q.push_back(stale);
    for (int i = 0; i < LEN; i++) begin
      idle_cycles($urandom_range(gap_lo, gap_hi));
      send_pair(g[i], x[i]);
    end
    if (mode == 0) exp_q.push_back({1'b0, engine_fn(g, x)});
    if (mode == 2) exp_q.push_back({1'b1, 512'b0});
  endtask

  task automatic drain();
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  curve_point_t [LEN-1:0]  dg;
  logic [LEN-1:0][255:0]   dx;
  logic [LEN-1:0][255:0]   zx;
  logic [LEN-1:0][255:0]   want_x;
  curve_point_t [LEN-1:0]  rg;
  logic [LEN-1:0][255:0]   rx;

  task automatic randomize_job();
    for (int i = 0; i < LEN; i++) begin
      rg[i] = '{x: rand256(), y: rand256()};
      rx[i] = rand256();
    end
  endtask

  initial begin
    int pulses0;
    bit seen;
    Reset = 1'b1;
    in_valid = 1'b0;
    in_G = '0;
    in_x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_eng_reset", eng_Reset, 1);
    check("rst_out_R", out_R, 0);
    check("rst_out_err", out_err, 0);
    check("rst_buffers", (eng_x == '0) && (eng_G == '0), 1);
    #1 Reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_eng_reset", eng_Reset, 0);

    // directed job, result held by consumer for 10 cycles
    dg[0] = '{x: 256'd6,  y: 256'd1};  dx[0] = 256'd18;
    dg[1] = '{x: 256'd17, y: 256'd6};  dx[1] = 256'd80;
    dg[2] = '{x: 256'd5,  y: 256'd13}; dx[2] = 256'd17;
    want_x = {256'd17, 256'd80, 256'd18};
    ready_mode = 1;
    pulses0 = n_pulse;
    run_job(dg, dx, 5, 1'b0, 0, 0, 0);
    check("load_eng_x", eng_x == want_x, 1);
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 0);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("first_out_valid_seen", seen, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_out_R", {out_err, out_R}, {1'b0, engine_fn(dg, dx)});
      check("hold_in_ready", in_ready, 0);
    end
    ready_mode = 2;
    drain();
    check("one_eng_reset_pulse", n_pulse - pulses0, 1);

    // back-to-back: same vectors, then all-zero scalars
    zx = '0;
    run_job(dg, dx, 4, 1'b0, 0, 0, 0);
    run_job(dg, zx, 3, 1'b1, 0, 0, 0);
    drain();

    // in_valid toggling every cycle with junk on idle cycles
    randomize_job();
    run_job(rg, rx, 6, 1'b0, 1, 1, 0);
    check("toggle_eng_x", eng_x == rx, 1);
    check("toggle_eng_G", eng_G == rg, 1);
    drain();

    // randomized jobs with random gaps, latency, stale Done and consumer back-pressure
    ready_mode = 0;
    for (int j = 0; j < 20; j++) begin
      randomize_job();
      run_job(rg, rx, $urandom_range(2, 12), 1'($urandom_range(0, 1)), 0, 2, 0);
    end
    drain();

    // reset while waiting for the engine, then a fresh job
    ready_mode = 2;
    randomize_job();
    run_job(rg, rx, 40, 1'b0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("wait_busy", busy, 1);
    Reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_eng_reset", eng_Reset, 1);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk);
    #2 Reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_recover_in_ready", in_ready, 1);
    randomize_job();
    run_job(rg, rx, 7, 1'b0, 0, 1, 0);
    drain();

`ifdef MSM_SEQ_TIMEOUT_EN
    // engine never raises Done
    randomize_job();
    run_job(rg, rx, 0, 1'b0, 0, 0, 2);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
